if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: REQ/WAIT/HOLD with at most one outstanding memory request.
// Optional build macro IF_PERF_CNT_EN adds a fetch_count output that counts deliveries.
module if_fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instruction
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q, discard_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] branch_tgt;
    logic        redirect_pending;
    logic        unused_addr_bits;

    assign branch_tgt       = {branch_addr[31:2], 2'b00};
    assign unused_addr_bits = ^branch_addr[1:0];

    // A redirect while a request is (or is about to be) in flight must squash its response.
    assign redirect_pending = ((state_q == S_WAIT) && !imem_rvalid) ||
                              ((state_q == S_REQ)  && imem_gnt);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        instr_d    = instr_q;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    discard_d = 1'b0;
                    if (discard_q) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                        instr_d = imem_rdata;
                        pc_d    = fetch_pc_q + 32'd4;
                        valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!freeze) begin
                    state_d    = S_REQ;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    valid_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (branch_taken) begin
            fetch_pc_d = branch_tgt;
            valid_d    = 1'b0;
            pc_d       = pc_q;
            instr_d    = instr_q;
            if (redirect_pending) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = S_REQ;
                discard_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= 32'd0;
            discard_q  <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= 32'd0;
            instr_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = fetch_pc_q;
    assign valid       = valid_q;
    assign pc          = pc_q;
    assign instruction = instr_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic        delivery;

    // A redirect in HOLD kills the held instruction, so it is not a delivery.
    assign delivery = (state_q == S_HOLD) && !freeze && !branch_taken;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count_q <= 32'd0;
        end else if (delivery) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: abstract model compared every cycle plus literal probes.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_gnt, imem_rvalid;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, valid;
    logic [31:0] imem_addr, pc, instruction;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int total = 0;
    int bad   = 0;
    int probe = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .valid        (valid),
        .pc           (pc),
        .instruction  (instruction)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    // Model: "busy" = a granted request whose response is still due; "stale" = that
    // response belongs to a redirected-away address. Requesting = neither busy nor holding.
    logic        m_init = 1'b0;
    logic        m_busy, m_stale, m_valid;
    logic [31:0] m_fetch, m_pc, m_instr, m_cnt;

    always @(posedge clk) begin
        if (!rst) begin
            m_init <= 1'b1; m_busy <= 1'b0; m_stale <= 1'b0; m_valid <= 1'b0;
            m_fetch <= 32'd0; m_pc <= 32'd0; m_instr <= 32'd0; m_cnt <= 32'd0;
        end else if (branch_taken) begin
            m_fetch <= branch_addr & 32'hFFFF_FFFC;
            m_valid <= 1'b0;
            m_busy  <= (m_busy && !imem_rvalid) || (!m_busy && !m_valid && imem_gnt);
            m_stale <= (m_busy && !imem_rvalid) || (!m_busy && !m_valid && imem_gnt);
        end else if (m_busy) begin
            if (imem_rvalid) begin
                m_busy  <= 1'b0;
                m_stale <= 1'b0;
                if (!m_stale) begin
                    m_instr <= imem_rdata;
                    m_pc    <= m_fetch + 32'd4;
                    m_valid <= 1'b1;
                end
            end
        end else if (m_valid) begin
            if (!freeze) begin
                m_fetch <= m_fetch + 32'd4;
                m_valid <= 1'b0;
                m_cnt   <= m_cnt + 32'd1;
            end
        end else if (imem_gnt) begin
            m_busy <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_req",   {31'd0, imem_req}, {31'd0, !m_busy && !m_valid});
            chk("model_addr",  imem_addr, m_fetch);
            chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
            chk("model_pc",    pc, m_pc);
            chk("model_instr", instruction, m_instr);
`ifdef IF_PERF_CNT_EN
            chk("model_cnt",   fetch_count, m_cnt);
`endif
        end
        case (probe)
            1: begin
                chk("rst_valid", {31'd0, valid}, 32'd0);
                chk("rst_pc", pc, 32'd0);
                chk("rst_instr", instruction, 32'd0);
                chk("rst_req", {31'd0, imem_req}, 32'd1);
            end
            2: chk("rel_addr", imem_addr, 32'd0);
            3: chk("wait_req", {31'd0, imem_req}, 32'd0);
            4: begin
                chk("hold_valid", {31'd0, valid}, 32'd1);
                chk("hold_pc", pc, 32'h0000_0004);
                chk("hold_instr", instruction, 32'hE3A0_1005);
                chk("hold_req", {31'd0, imem_req}, 32'd0);
            end
            5: begin
                chk("adv_req", {31'd0, imem_req}, 32'd1);
                chk("adv_addr", imem_addr, 32'h0000_0004);
                chk("adv_valid", {31'd0, valid}, 32'd0);
            end
            6: begin
                chk("br_wait_addr", imem_addr, 32'h0000_0100);
                chk("br_wait_valid", {31'd0, valid}, 32'd0);
            end
            7: begin
                chk("br_req_addr", imem_addr, 32'h0000_0100);
                chk("br_req_valid", {31'd0, valid}, 32'd0);
                chk("br_instr_kept", instruction, 32'hE3A0_1005);
            end
            8: chk("hold2_pc", pc, 32'h0000_0104);
            9: begin
                chk("brfz_valid", {31'd0, valid}, 32'd0);
                chk("brfz_addr", imem_addr, 32'h0000_0200);
            end
            10: chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
            12: begin
                chk("wrap_pc", pc, 32'h0000_0000);
                chk("wrap_valid", {31'd0, valid}, 32'd1);
            end
            13: chk("wrap_next_addr", imem_addr, 32'h0000_0000);
            14: begin
                chk("brrv_addr", imem_addr, 32'h0000_0040);
                chk("brrv_instr", instruction, 32'h2222_2222);
            end
            15: begin
                chk("rstw_valid", {31'd0, valid}, 32'd0);
                chk("rstw_instr", instruction, 32'd0);
                chk("rstw_addr", imem_addr, 32'd0);
            end
            16: begin
                chk("loop_addr", imem_addr, 32'h0000_0014);
                chk("loop_pc", pc, 32'h0000_0014);
                chk("loop_instr", instruction, 32'h0000_00A4);
`ifdef IF_PERF_CNT_EN
                chk("cnt_five", fetch_count, 32'd5);
`endif
            end
            17: begin
                chk("rst2_valid", {31'd0, valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
                chk("cnt_zero", fetch_count, 32'd0);
`endif
            end
            default: ;
        endcase
    end

    task automatic cyc(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                       input logic fz, input logic br, input logic [31:0] ba, input int pr);
        rst = r; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        freeze = fz; branch_taken = br; branch_addr = ba; probe = pr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(0, 0, 0, 32'd0, 0, 0, 32'd0, 1);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 2);
        cyc(1, 0, 1, 32'hE3A0_1005, 0, 0, 32'd0, 3);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'd0, 1, 0, 32'd0, 4);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 4);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 5);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(1, 0, 0, 32'd0, 0, 1, 32'h0000_0103, 0);
        cyc(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'd0, 6);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 7);
        cyc(1, 0, 1, 32'h1111_1111, 0, 0, 32'd0, 0);
        cyc(1, 0, 0, 32'd0, 1, 1, 32'h0000_0200, 8);
        cyc(1, 1, 0, 32'd0, 0, 1, 32'hFFFF_FFFF, 9);
        cyc(1, 0, 1, 32'h0000_0BAD, 0, 0, 32'd0, 0);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 10);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(1, 0, 1, 32'h2222_2222, 0, 0, 32'd0, 0);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 12);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 13);
        cyc(1, 0, 1, 32'h3333_3333, 0, 1, 32'h0000_0040, 0);
        cyc(1, 0, 1, 32'h4444_4444, 0, 0, 32'd0, 14);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 14);
        cyc(0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(1, 0, 1, 32'h5555_5555, 0, 0, 32'd0, 15);
        cyc(1, 1, 0, 32'd0, 0, 1, 32'd0, 15);
        cyc(1, 0, 1, 32'h6666_6666, 0, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 0);
            cyc(1, 0, 1, 32'h0000_00A0 + 32'(i), 0, 0, 32'd0, 0);
            cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        end
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 16);
        cyc(1, 1, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 17);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        cyc(1, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
